vga_sync_gen: RTL and testbench

//  Raster timing generator; sits directly upstream of the pixel renderers (bitmapped digit/sprite stages).

---
 rtl/vga_sync_gen_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 25 ++
 rtl/vga_sync_gen.sv | 106 ++++++++++
 tb/tb_vga_sync_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing defaults (640x480@60) and the registered output bundle
// used by the sync generator, renderers and benches.
package vga_sync_gen_pkg;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int POS_W   = 10;
   localparam int POS_MAX = 1 << POS_W;

   typedef struct packed {
      logic [POS_W-1:0] hpos;
      logic [POS_W-1:0] vpos;
      logic             visible;
      logic             hsync;
      logic             vsync;
      logic             line_start;
      logic             frame_start;
   } raster_t;

   // Half-open window test [lo, hi).
   function automatic logic in_window(input int pos, input int lo, input int hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; wrap flags the terminal count.
module vga_axis_counter #(
   parameter int TOTAL = 800,
   parameter int W     = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   // >= rather than == so a corrupted count above LAST folds back to 0.
   assign wrap = (count >= LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, window decode and a registered
// output bank so position, visible and sync leave the block with zero skew.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int SYNC_POL  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [POS_W-1:0] o_hpos,
   output logic [POS_W-1:0] o_vpos,
   output logic             o_visible,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_line_start,
   output logic             o_frame_start
);

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam logic SYNC_ON    = (SYNC_POL != 0);

   generate
      if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_bad_totals
         $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
      end
   endgenerate

   logic [POS_W-1:0] h_count;
   logic [POS_W-1:0] v_count;
   logic             h_wrap;
   logic             v_wrap;
   logic             v_en;

   assign v_en = i_en & h_wrap;

   vga_axis_counter #(.TOTAL(H_TOTAL), .W(POS_W)) u_h_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .en      (i_en),
      .count   (h_count),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL), .W(POS_W)) u_v_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .en      (v_en),
      .count   (v_count),
      .wrap    (v_wrap)
   );

   raster_t decode;
   raster_t q;

   always_comb begin
      decode             = '0;
      decode.hpos        = h_count;
      decode.vpos        = v_count;
      decode.visible     = in_window(int'(h_count), 0, H_VISIBLE) &&
                           in_window(int'(v_count), 0, V_VISIBLE);
      decode.hsync       = in_window(int'(h_count), H_SYNC_START, H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      decode.vsync       = in_window(int'(v_count), V_SYNC_START, V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      decode.line_start  = (h_count == '0);
      decode.frame_start = (h_count == '0) && (v_count == '0);
   end

   // Strobes drop on any clock without an enabled edge, so they never stretch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q       <= '0;
         q.hsync <= ~SYNC_ON;
         q.vsync <= ~SYNC_ON;
      end else if (i_en) begin
         q <= decode;
      end else begin
         q.line_start  <= 1'b0;
         q.frame_start <= 1'b0;
      end
   end

   assign o_hpos        = q.hpos;
   assign o_vpos        = q.vpos;
   assign o_visible     = q.visible;
   assign o_hsync       = q.hsync;
   assign o_vsync       = q.vsync;
   assign o_line_start  = q.line_start;
   assign o_frame_start = q.frame_start;

   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (15x13) so whole frames fit in a short run.
module tb_vga_sync_gen;

   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 6, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [9:0] hpos, vpos;
   logic       visible, hsync, vsync, line_start, frame_start;

   int checks = 0;
   int failures = 0;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(0)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .o_hpos        (hpos),
      .o_vpos        (vpos),
      .o_visible     (visible),
      .o_hsync       (hsync),
      .o_vsync       (vsync),
      .o_line_start  (line_start),
      .o_frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Reference: a linear pixel index through the frame; everything else is arithmetic on it.
   int  next_pix = 0;
   int  shown_pix = 0;
   bit  shown = 0;
   bit  strobe = 0;

   function automatic logic [24:0] pk(input int h, input int v, input bit vis, input bit hs,
                                      input bit vs, input bit ls, input bit fs);
      logic [9:0] h10, v10;
      h10 = h[9:0];
      v10 = v[9:0];
      return {h10, v10, vis, hs, vs, ls, fs};
   endfunction

   function automatic logic [24:0] model_vec();
      int h, v;
      if (!shown) return pk(0, 0, 0, 1, 1, 0, 0);
      h = shown_pix % HT;
      v = shown_pix / HT;
      return pk(h, v, (h < HV) && (v < VV),
                !((h >= HV + HF) && (h < HV + HF + HS)),
                !((v >= VV + VF) && (v < VV + VF + VS)),
                strobe, strobe && (v == 0));
   endfunction

   function automatic logic [24:0] dut_vec();
      return {hpos, vpos, visible, hsync, vsync, line_start, frame_start};
   endfunction

   task automatic check(input string name, input logic [24:0] expv);
      logic [24:0] act;
      act = dut_vec();
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b, want h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b",
                  name, act[24:15], act[14:5], act[4], act[3], act[2], act[1], act[0],
                  expv[24:15], expv[14:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
      end
   endtask

   task automatic model_reset();
      next_pix = 0;
      shown_pix = 0;
      shown = 0;
      strobe = 0;
   endtask

   // One clock: drive at negedge, update the model at posedge, leave time at posedge+1.
   task automatic cycle(input logic r, input logic e);
      @(negedge clk);
      rst_n = r;
      en = e;
      @(posedge clk);
      if (!r) begin
         model_reset();
      end else if (e) begin
         shown_pix = next_pix;
         shown = 1;
         next_pix = (next_pix + 1) % FR;
         strobe = (shown_pix % HT) == 0;
      end else begin
         strobe = 0;
      end
      #1;
   endtask

   typedef struct {
      logic        r;
      logic        e;
      logic [24:0] expv;
   } vec_t;

   // Enable pattern: always / alternate. Returns clocks between frame_start pulses.
   task automatic measure_frame(input bit toggle, output int len);
      int  t = 0;
      int  cnt = 0;
      bit  seen = 0;
      len = -1;
      while (t < 3 * 2 * FR + 10) begin
         cycle(1, toggle ? t[0] == 1'b0 : 1'b1);
         check("frame_walk", model_vec());
         cnt++;
         if (frame_start) begin
            if (seen) begin
               len = cnt;
               break;
            end
            seen = 1;
            cnt = 0;
         end
         t++;
      end
   endtask

   initial begin
      vec_t tbl[$];
      int   len;
      int   hw_lo, hw_hi;

      tbl.push_back('{1'b0, 1'b0, pk(0, 0, 0, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b1, pk(0, 0, 1, 1, 1, 1, 1)});
      tbl.push_back('{1'b1, 1'b1, pk(1, 0, 1, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b0, pk(1, 0, 1, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b1, pk(2, 0, 1, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b0, pk(2, 0, 1, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b0, pk(2, 0, 1, 1, 1, 0, 0)});
      tbl.push_back('{1'b1, 1'b1, pk(3, 0, 1, 1, 1, 0, 0)});

      for (int i = 0; i < 10; i++) cycle(0, 0);
      check("reset_hold", pk(0, 0, 0, 1, 1, 0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].r, tbl[i].e);
         check($sformatf("table_%0d", i), tbl[i].expv);
      end

      // Walk the rest of line 0 and into line 1, tracking hsync window and wrap.
      hw_lo = -1;
      hw_hi = -1;
      for (int i = 0; i < HT + 2; i++) begin
         cycle(1, 1);
         check("line_walk", model_vec());
         if (vpos == 10'd0 && !hsync) begin
            if (hw_lo < 0) hw_lo = int'(hpos);
            hw_hi = int'(hpos);
         end
      end
      checks++;
      if (hw_lo != HV + HF || hw_hi != HV + HF + HS - 1) begin
         failures++;
         $display("FAIL hsync_window: got %0d..%0d want %0d..%0d", hw_lo, hw_hi, HV + HF, HV + HF + HS - 1);
      end

      measure_frame(0, len);
      checks++;
      if (len != FR) begin
         failures++;
         $display("FAIL frame_len_en1: got %0d want %0d", len, FR);
      end
      measure_frame(1, len);
      checks++;
      if (len != 2 * FR) begin
         failures++;
         $display("FAIL frame_len_toggle: got %0d want %0d", len, 2 * FR);
      end

      // Mid-frame reset at (5,4): outputs must drop without waiting for a clock.
      cycle(0, 0);
      for (int i = 0; i < 4 * HT + 6; i++) cycle(1, 1);
      check("pre_reset_pos", pk(5, 4, 1, 1, 1, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_reset", model_vec());
      cycle(0, 1);
      cycle(1, 1);
      check("restart_origin", pk(0, 0, 1, 1, 1, 1, 1));

      // Random enable and occasional reset against the model.
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0));
         check("random", model_vec());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
